// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants: sync header encodings, block-lock thresholds
// and the block-lock controller state type.
package eth_pcs_params;

  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  localparam int SH_TH         = 64;
  localparam int SH_INVAL_TH   = 16;
  localparam int W_SH_TH       = $clog2(SH_TH);
  localparam int W_SH_INVAL_TH = $clog2(SH_INVAL_TH);

  // Header strobes to ignore after a slip while the gearbox settles.
  localparam int LOCK_SLIP_HOLD = 2;

  typedef enum logic [1:0] {RESET_CNT, TEST_SH, SLIP_WAIT} lock_state_t;

  function automatic logic sync_hdr_ok(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_lock.sv
// 10GBASE-R receive block-lock controller: slips the gearbox one bit at a time
// until a full window of valid sync headers is seen, then tracks lock loss.
module eth_pcs_rx_block_lock
  import eth_pcs_params::*;
#(
  parameter int SH_CNT_TH       = SH_TH,
  parameter int SH_INVAL_CNT_TH = SH_INVAL_TH,
  parameter int SLIP_HOLD       = LOCK_SLIP_HOLD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hdr_valid,
  input  logic [W_SYNC-1:0] i_sync_hdr,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_sh_err
);

  localparam int CNT_W  = W_SH_TH + 1;
  localparam int INV_W  = W_SH_INVAL_TH + 1;
  localparam int HOLD_W = (SLIP_HOLD > 1) ? $clog2(SLIP_HOLD + 1) : 1;

  localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(SH_CNT_TH - 1);
  localparam logic [INV_W-1:0]  INV_LIM  = INV_W'(SH_INVAL_CNT_TH);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(SLIP_HOLD);

  lock_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  sh_cnt_reg, sh_cnt_next;
  logic [INV_W-1:0]  inval_cnt_reg, inval_cnt_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              slip_reg, slip_next;
  logic              lock_reg, lock_next;
  logic              sh_err_reg, sh_err_next;

  logic sh_ok;
  logic win_end;
  logic inval_hit;

  assign sh_ok     = sync_hdr_ok(i_sync_hdr);
  assign win_end   = (sh_cnt_reg == WIN_LAST);
  assign inval_hit = ((inval_cnt_reg + INV_W'(1)) == INV_LIM);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= RESET_CNT;
      sh_cnt_reg    <= '0;
      inval_cnt_reg <= '0;
      hold_reg      <= '0;
      slip_reg      <= 1'b0;
      lock_reg      <= 1'b0;
      sh_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sh_cnt_reg    <= sh_cnt_next;
      inval_cnt_reg <= inval_cnt_next;
      hold_reg      <= hold_next;
      slip_reg      <= slip_next;
      lock_reg      <= lock_next;
      sh_err_reg    <= sh_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sh_cnt_next    = sh_cnt_reg;
    inval_cnt_next = inval_cnt_reg;
    hold_next      = hold_reg;
    case (state_reg)
      RESET_CNT: begin
        sh_cnt_next    = '0;
        inval_cnt_next = '0;
        state_next     = TEST_SH;
      end
      TEST_SH: begin
        if (i_hdr_valid) begin
          if (sh_ok) begin
            if (win_end) begin
              sh_cnt_next    = '0;
              inval_cnt_next = '0;
              state_next     = RESET_CNT;
            end else begin
              sh_cnt_next = sh_cnt_reg + CNT_W'(1);
            end
          end else if (!lock_reg || inval_hit) begin
            sh_cnt_next    = '0;
            inval_cnt_next = '0;
            hold_next      = HOLD_LD;
            state_next     = SLIP_WAIT;
          end else if (win_end) begin
            sh_cnt_next    = '0;
            inval_cnt_next = '0;
            state_next     = RESET_CNT;
          end else begin
            sh_cnt_next    = sh_cnt_reg + CNT_W'(1);
            inval_cnt_next = inval_cnt_reg + INV_W'(1);
          end
        end
      end
      SLIP_WAIT: begin
        // Leave on the strobe that drains the hold count; a zero hold exits at once.
        if (hold_reg == '0) begin
          state_next = RESET_CNT;
        end else if (i_hdr_valid) begin
          hold_next = hold_reg - HOLD_W'(1);
          if (hold_reg == HOLD_W'(1)) begin
            state_next = RESET_CNT;
          end
        end
      end
      default: state_next = RESET_CNT;
    endcase
  end

  always_comb begin
    slip_next   = 1'b0;
    sh_err_next = 1'b0;
    lock_next   = lock_reg;
    if ((state_reg == TEST_SH) && i_hdr_valid) begin
      if (sh_ok) begin
        if (win_end && (inval_cnt_reg == '0)) begin
          lock_next = 1'b1;
        end
      end else begin
        sh_err_next = 1'b1;
        if (!lock_reg || inval_hit) begin
          lock_next = 1'b0;
          slip_next = 1'b1;
        end
      end
    end
  end

  assign o_slip       = slip_reg;
  assign o_block_lock = lock_reg;
  assign o_sh_err     = sh_err_reg;

endmodule
